// File: rtl/vr_rr_arbiter.sv
// Round-robin arbiter: merges NUM_REQ valid/ready transmitters onto one
// valid/ready receiver through a single output register stage. Each output
// word carries the index of the transmitter that supplied it. The most
// recent winner gets the lowest priority in the next arbitration.
module vr_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int SRC_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            in_valid,
  output logic [NUM_REQ-1:0]            in_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [SRC_W-1:0]              out_src
);

  logic [SRC_W-1:0]      ptr_r;       // highest-priority requester index
  logic [SRC_W-1:0]      win_s;       // selected requester
  logic                  any_s;       // at least one requester valid
  logic                  load_s;      // output register empty or draining
  logic [SRC_W-1:0]      ptr_nxt_s;   // winner + 1, wrapped
  logic [DATA_WIDTH-1:0] win_data_s;  // data word of the winner

  // Output stage can take a new word when empty or being drained this cycle.
  assign load_s = !out_valid || out_ready;

  // Scan from ptr upward with wrap; the lowest offset that is valid wins.
  always_comb begin
    win_s = '0;
    any_s = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (in_valid[(int'(ptr_r) + k) % NUM_REQ]) begin
        win_s = SRC_W'((int'(ptr_r) + k) % NUM_REQ);
        any_s = 1'b1;
      end else begin
        win_s = win_s;
        any_s = any_s;
      end
    end
  end

  // Winner data mux and next pointer (wraps from NUM_REQ-1 back to 0).
  always_comb begin
    win_data_s = in_data[int'(win_s)*DATA_WIDTH +: DATA_WIDTH];
    if (win_s == SRC_W'(NUM_REQ - 1)) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = win_s + SRC_W'(1);
    end
  end

  // One-hot ready to the winner; nothing is accepted while in reset.
  always_comb begin
    in_ready = '0;
    if (!rst && load_s && any_s) begin
      in_ready[win_s] = 1'b1;
    end else begin
      in_ready = '0;
    end
  end

  // Output register and round-robin pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr_r     <= '0;
    end else if (load_s) begin
      if (any_s) begin
        out_valid <= 1'b1;
        out_data  <= win_data_s;
        out_src   <= win_s;
        ptr_r     <= ptr_nxt_s;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vr_rr_arbiter.sv
// Directed self-checking bench for vr_rr_arbiter (NUM_REQ=4, DATA_WIDTH=8).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_vr_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_src;

  int checks_cnt = 0;
  int errors_cnt = 0;

  vr_rr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [1:0] src, input logic [7:0] data);
    check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check_eq({tag, "_src"}, {30'd0, out_src}, {30'd0, src});
    check_eq({tag, "_data"}, {24'd0, out_data}, {24'd0, data});
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 4'hF;
    in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    out_ready = 1'b1;

    // 1. reset held with all requests valid
    step();
    for (int i = 0; i < 3; i++) begin
      check_eq("rst_in_ready", {28'd0, in_ready}, 32'd0);
      check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check_eq("rst_out_src", {30'd0, out_src}, 32'd0);
      check_eq("rst_out_data", {24'd0, out_data}, 32'd0);
      step();
    end

    // 2. all valid, full rate rotation 0,1,2,3,0
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("rot_in_ready", {28'd0, in_ready}, 32'd1 << (i % 4));
      step();
      check_out("rot", 2'(i % 4), 8'hA0 + 8'(i % 4));
    end

    // 3. only req 2 for five words (ptr=1 before)
    in_valid = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("solo_in_ready", {28'd0, in_ready}, 32'h4);
      step();
      check_out("solo", 2'd2, 8'hA2);
    end
    // ptr=3: req 3 before req 1
    in_valid = 4'b1010;
    #1;
    check_eq("pair_in_ready3", {28'd0, in_ready}, 32'h8);
    step();
    check_out("pair3", 2'd3, 8'hA3);
    in_valid = 4'b0010;
    #1;
    check_eq("pair_in_ready1", {28'd0, in_ready}, 32'h2);
    step();
    check_out("pair1", 2'd1, 8'hA1);
    // no request: output drains to empty, ptr stays 2
    in_valid = 4'b0000;
    step();
    check_eq("idle_out_valid", {31'd0, out_valid}, 32'd0);

    // 4. backpressure
    in_valid  = 4'hF;
    out_ready = 1'b0;
    #1;
    check_eq("bp_load_ready", {28'd0, in_ready}, 32'h4);
    step();
    for (int i = 0; i < 4; i++) begin
      check_eq("bp_in_ready", {28'd0, in_ready}, 32'd0);
      check_out("bp_hold", 2'd2, 8'hA2);
      step();
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", {28'd0, in_ready}, 32'h8);
    step();
    check_out("bp_next", 2'd3, 8'hA3);

    // 5. wrap: ptr=0 -> serve req 2 to reach ptr=3
    in_valid = 4'b0100;
    step();
    check_out("wrap_pre", 2'd2, 8'hA2);
    in_valid = 4'b1001;
    #1;
    check_eq("wrap_ready3", {28'd0, in_ready}, 32'h8);
    step();
    check_out("wrap3", 2'd3, 8'hA3);
    in_valid = 4'b0001;
    #1;
    check_eq("wrap_ready0", {28'd0, in_ready}, 32'h1);
    step();
    check_out("wrap0", 2'd0, 8'hA0);
    // ptr=1 now: req 1 beats req 0
    in_valid = 4'b0011;
    #1;
    check_eq("wrap_ptr1_ready", {28'd0, in_ready}, 32'h2);
    step();
    check_out("wrap_ptr1", 2'd1, 8'hA1);

    // 6. reset mid-stream (ptr=2 before reset)
    out_ready = 1'b0;
    in_valid  = 4'b1110;
    step();
    check_out("mid_hold", 2'd1, 8'hA1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_ready", {28'd0, in_ready}, 32'd0);
    step();
    check_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("mid_rst_src", {30'd0, out_src}, 32'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    check_eq("post_rst_ready", {28'd0, in_ready}, 32'h2);
    step();
    check_out("post_rst", 2'd1, 8'hA1);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
